fixed_power: RTL and testbench

//  Raises an unsigned Q10.10 fixed-point base to a small integer power n (0..7) by iterative multiply.

---
 rtl/fixed_pkg.sv | 19 +
 rtl/fixed_power_q_mul_sat.sv | 47 ++++
 rtl/fixed_power.sv | 129 ++++++++++++
 tb/tb_fixed_power.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared constants and types for the Q10.10 arithmetic units
// (power, root, division).
//   Q_FRAC/Q_WIDTH : fraction bits and total width of a Q10.10 operand
//   Q_ONE          : 1.0 in Q10.10
//   Q_MAX          : saturation value (largest representable Q10.10)
//   pow_state_t    : control states of the iterative power unit
package fixed_pkg;

  localparam int          Q_FRAC  = 10;
  localparam int          Q_WIDTH = 20;
  localparam logic [19:0] Q_ONE   = 20'h00400;
  localparam logic [19:0] Q_MAX   = 20'hFFFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } pow_state_t;

endpackage : fixed_pkg

// File: rtl/fixed_power_q_mul_sat.sv
// q_mul_sat: combinational unsigned fixed-point multiply with truncation and
// sticky saturation. The full product is shifted right by W_FRAC (truncating
// toward zero); if any integer bits beyond W_INT survive, or sat_in is already
// set, the result saturates to all ones and sat is raised.
//   op_a, op_b : unsigned operands, W_INT.W_FRAC
//   sat_in     : incoming sticky overflow flag
//   prod       : truncated or saturated product, W_INT.W_FRAC
//   sat        : outgoing sticky overflow flag
module q_mul_sat
  import fixed_pkg::*;
#(
  parameter int W_INT  = Q_WIDTH - Q_FRAC,
  parameter int W_FRAC = Q_FRAC
) (
  input  logic [W_INT+W_FRAC-1:0] op_a,
  input  logic [W_INT+W_FRAC-1:0] op_b,
  input  logic                    sat_in,
  output logic [W_INT+W_FRAC-1:0] prod,
  output logic                    sat
);

  localparam int W  = W_INT + W_FRAC;
  localparam int PW = 2 * W;        // full product width
  localparam int SW = PW - W_FRAC;  // width after dropping fraction bits

  logic [PW-1:0]    full_s;
  logic [SW-1:0]    shifted_s;
  logic [W_INT-1:0] high_s;

  assign full_s    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
  assign shifted_s = full_s[PW-1:W_FRAC];
  assign high_s    = shifted_s[SW-1:W];

  // Saturate when the product no longer fits, or once overflow has occurred.
  always_comb begin
    prod = shifted_s[W-1:0];
    sat  = 1'b0;
    if (sat_in || (high_s != {W_INT{1'b0}})) begin
      prod = {W{1'b1}};
      sat  = 1'b1;
    end else begin
      prod = shifted_s[W-1:0];
      sat  = 1'b0;
    end
  end

endmodule : q_mul_sat

// File: rtl/fixed_power.sv
// fixed_power: raises an unsigned Q10.10 base to an integer power n by
// repeated multiply, one step per clock, with sticky saturation.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : request strobe, accepted only while in_ready=1
//   in_data_1  : base (unsigned Q10.10)
//   in_data_2  : exponent n
//   in_ready   : high while idle
//   out_valid  : one-cycle result strobe
//   out_data   : base^n in Q10.10 (0 when out_valid=0)
//   out_ovf    : result saturated (0 when out_valid=0)
module fixed_power
  import fixed_pkg::*;
#(
  parameter int W_INT  = 10,
  parameter int W_FRAC = 10,
  parameter int W_EXP  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [W_INT+W_FRAC-1:0] in_data_1,
  input  logic [W_EXP-1:0]        in_data_2,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [W_INT+W_FRAC-1:0] out_data,
  output logic                    out_ovf
);

  localparam int            W     = W_INT + W_FRAC;
  localparam logic [W-1:0]  ONE_C = {{(W-1){1'b0}}, 1'b1} << W_FRAC;

  pow_state_t        state_r, state_s;
  logic [W-1:0]      base_r, base_s;
  logic [W_EXP-1:0]  exp_r, exp_s;
  logic [W_EXP-1:0]  cnt_r, cnt_s;
  logic [W-1:0]      acc_r, acc_s;
  logic              ovf_r, ovf_s;
  logic              out_valid_r, out_valid_s;
  logic [W-1:0]      out_data_r, out_data_s;
  logic              out_ovf_r, out_ovf_s;
  logic [W-1:0]      mul_prod_s;
  logic              mul_sat_s;

  q_mul_sat #(
    .W_INT  (W_INT),
    .W_FRAC (W_FRAC)
  ) u_mul (
    .op_a   (acc_r),
    .op_b   (base_r),
    .sat_in (ovf_r),
    .prod   (mul_prod_s),
    .sat    (mul_sat_s)
  );

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= {W{1'b0}};
      exp_r       <= {W_EXP{1'b0}};
      cnt_r       <= {W_EXP{1'b0}};
      acc_r       <= ONE_C;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      exp_r       <= exp_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      ovf_r       <= ovf_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_ovf_r   <= out_ovf_s;
    end
  end

  // Next-state and next-output logic; outputs default to zero so the
  // result strobe lasts exactly one cycle.
  always_comb begin
    state_s     = state_r;
    base_s      = base_r;
    exp_s       = exp_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    ovf_s       = ovf_r;
    out_valid_s = 1'b0;
    out_data_s  = {W{1'b0}};
    out_ovf_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          base_s  = in_data_1;
          exp_s   = in_data_2;
          acc_s   = ONE_C;
          cnt_s   = {W_EXP{1'b0}};
          ovf_s   = 1'b0;
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        // One multiply per cycle until n steps are done, then publish.
        if (cnt_r == exp_r) begin
          out_valid_s = 1'b1;
          out_data_s  = acc_r;
          out_ovf_s   = ovf_r;
          state_s     = IDLE;
        end else begin
          acc_s = mul_prod_s;
          ovf_s = mul_sat_s;
          cnt_s = cnt_r + {{(W_EXP-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule : fixed_power

// File: tb/tb_fixed_power.sv
// tb_fixed_power: directed and randomized checks of fixed_power against a
// plain-arithmetic reference model of base^n with per-step truncation and
// sticky saturation.
module tb_fixed_power;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_data_1 = 20'h0;
  logic [2:0]  in_data_2 = 3'h0;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  fixed_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: n truncating multiplies starting from 1.0; once any step
  // exceeds the Q10.10 range the result stays at the maximum.
  function automatic void model(input logic [19:0] b, input logic [2:0] n,
                                output logic [19:0] res, output logic ovf);
    longint acc;
    longint p;
    bit     ov;
    acc = 1024;
    ov  = 0;
    for (int i = 0; i < int'(n); i++) begin
      p = (acc * longint'(b)) / 1024;
      if (ov || p > 64'hFFFFF) begin
        acc = 64'hFFFFF;
        ov  = 1;
      end else begin
        acc = p;
      end
    end
    res = acc[19:0];
    ovf = ov;
  endfunction

  // Issue one request at the current negedge and wait for its result.
  // Returns at the negedge where out_valid is high.
  task automatic send(input logic [19:0] b, input logic [2:0] n, input bit pulse, input string tag);
    logic [19:0] er;
    logic        eo;
    int          cyc;
    model(b, n, er, eo);
    chk({tag, " in_ready_idle"}, {31'h0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data_1 = b;
    in_data_2 = n;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = 20'($urandom);
    in_data_2 = 3'($urandom);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      chk({tag, " in_ready_busy"}, {31'h0, in_ready}, 32'd0);
      chk({tag, " data_zero_busy"}, {12'h0, out_data}, 32'd0);
      in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'(int'(n) + 1));
    chk({tag, " data"}, {12'h0, out_data}, {12'h0, er});
    chk({tag, " ovf"}, {31'h0, out_ovf}, {31'h0, eo});
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " valid_one_cycle"}, {31'h0, out_valid}, 32'd0);
    chk({tag, " data_zero"}, {12'h0, out_data}, 32'd0);
    chk({tag, " ovf_zero"}, {31'h0, out_ovf}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst out_data", {12'h0, out_data}, 32'd0);
    chk("rst out_ovf", {31'h0, out_ovf}, 32'd0);
    chk("rst in_ready", {31'h0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 2.0^3 = 8.0
    send(20'h00800, 3'd3, 1'b0, "t1");
    chk("t1 const", {12'h0, out_data}, 32'h02000);
    idle_check("t1");

    // 1.5^2 = 2.25, then tiny base truncates to zero
    send(20'h00600, 3'd2, 1'b0, "t2a");
    chk("t2a const", {12'h0, out_data}, 32'h00900);
    idle_check("t2a");
    send(20'h00001, 3'd2, 1'b0, "t2b");
    chk("t2b const", {12'h0, out_data}, 32'h00000);
    idle_check("t2b");

    // n=0 gives 1.0 for any base
    send(20'h00000, 3'd0, 1'b0, "t3a");
    chk("t3a const", {12'h0, out_data}, 32'h00400);
    idle_check("t3a");
    send(20'hFFFFF, 3'd0, 1'b0, "t3b");
    chk("t3b const", {12'h0, out_data}, 32'h00400);
    idle_check("t3b");

    // Saturation, then ovf cleared on the next request
    send(20'h20000, 3'd3, 1'b0, "t4a");
    chk("t4a const", {12'h0, out_data}, 32'hFFFFF);
    chk("t4a ovf const", {31'h0, out_ovf}, 32'd1);
    idle_check("t4a");
    send(20'h00400, 3'd7, 1'b0, "t4b");
    chk("t4b const", {12'h0, out_data}, 32'h00400);
    chk("t4b ovf const", {31'h0, out_ovf}, 32'd0);
    idle_check("t4b");

    // Back-to-back with ignored in_valid pulses during MUL
    send(20'h00600, 3'd2, 1'b1, "t5a");
    send(20'h00C00, 3'd3, 1'b1, "t5b");
    send(20'h00800, 3'd0, 1'b1, "t5c");
    idle_check("t5");
    repeat (3) begin
      @(negedge clk);
      chk("t5 no_extra_valid", {31'h0, out_valid}, 32'd0);
    end

    // Reset mid-MUL aborts with no result
    in_valid  = 1'b1;
    in_data_1 = 20'h00800;
    in_data_2 = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6 rst out_valid", {31'h0, out_valid}, 32'd0);
    chk("t6 rst out_data", {12'h0, out_data}, 32'd0);
    chk("t6 rst out_ovf", {31'h0, out_ovf}, 32'd0);
    chk("t6 rst in_ready", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6 no_valid_after_abort", {31'h0, out_valid}, 32'd0);
    end
    send(20'h00800, 3'd3, 1'b0, "t6b");
    chk("t6b const", {12'h0, out_data}, 32'h02000);
    idle_check("t6b");

    // Randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      logic [19:0] b;
      case ($urandom_range(0, 2))
        0:       b = 20'($urandom_range(0, 32'h00800));
        1:       b = 20'($urandom_range(0, 32'h03000));
        default: b = 20'($urandom);
      endcase
      send(b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 1) == 1) idle_check("rnd");
    end
    idle_check("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fixed_power
